// File: rtl/shift_engine_arbiter.sv
// Round-robin owner of a shared word-serial shift engine: grants one requester at a time,
// pulses the engine start, steers the engine's RAM ports to the owner and returns done.
module shift_engine_arbiter #(
    parameter int K = 128,
    parameter int N = 32,
    parameter int R = 4,
    localparam int ADDR_W = $clog2(N)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [R-1:0]        req,
    output logic [R-1:0]        grant,
    output logic [R-1:0]        done,
    output logic                busy,
    output logic                eng_start,
    input  logic                eng_end,
    input  logic [ADDR_W-1:0]   eng_rd_addr,
    output logic [K-1:0]        eng_rd_data,
    input  logic [ADDR_W-1:0]   eng_wr_addr,
    input  logic [K-1:0]        eng_wr_data,
    input  logic                eng_wr_en,
    output logic [ADDR_W-1:0]   rq_rd_addr,
    input  logic [R*K-1:0]      rq_rd_data,
    output logic [ADDR_W-1:0]   rq_wr_addr,
    output logic [K-1:0]        rq_wr_data,
    output logic [R-1:0]        rq_wr_en
);

    localparam int PTR_W = $clog2(R);
    localparam logic [PTR_W:0] R_W = (PTR_W+1)'(R);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t             state_r, state_s;
    logic [PTR_W-1:0]   ptr_r, ptr_s;
    logic [PTR_W-1:0]   winner_r, winner_s;
    logic [R-1:0]       grant_r, grant_s;
    logic [R-1:0]       done_r, done_s;
    logic               start_r, start_s;
    logic               busy_r, busy_s;
    logic [PTR_W-1:0]   pick_s;
    logic [PTR_W-1:0]   cand_s;
    logic [PTR_W:0]     sum_s;
    logic [PTR_W-1:0]   next_ptr_s;
    logic [K-1:0]       rd_mux_s;

    function automatic logic [R-1:0] onehot(input logic [PTR_W-1:0] idx);
        onehot = {{(R-1){1'b0}}, 1'b1} << idx;
    endfunction

    // Round-robin pick: scan offsets high to low so the smallest offset from ptr wins.
    always_comb begin
        pick_s = ptr_r;
        cand_s = ptr_r;
        sum_s  = '0;
        for (int i = R - 1; i >= 0; i--) begin
            sum_s = {1'b0, ptr_r} + (PTR_W+1)'(i);
            if (sum_s >= R_W) begin
                cand_s = PTR_W'(sum_s - R_W);
            end else begin
                cand_s = PTR_W'(sum_s);
            end
            if (req[cand_s]) begin
                pick_s = cand_s;
            end else begin
                pick_s = pick_s;
            end
        end
    end

    // Pointer advances past the winner, wrapping at R.
    always_comb begin
        if (winner_r == PTR_W'(R - 1)) begin
            next_ptr_s = '0;
        end else begin
            next_ptr_s = winner_r + PTR_W'(1);
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_s  = state_r;
        ptr_s    = ptr_r;
        winner_s = winner_r;
        grant_s  = grant_r;
        done_s   = '0;
        start_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (req != '0) begin
                    winner_s = pick_s;
                    grant_s  = onehot(pick_s);
                    start_s  = 1'b1;
                    state_s  = ST_GRANT;
                end else begin
                    grant_s  = '0;
                end
            end
            // A zero-latency engine may end while still in GRANT.
            ST_GRANT, ST_RUN: begin
                if (eng_end) begin
                    grant_s = '0;
                    done_s  = onehot(winner_r);
                    ptr_s   = next_ptr_s;
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_DONE: begin
                grant_s = '0;
                state_s = ST_IDLE;
            end
            default: begin
                grant_s = '0;
                state_s = ST_IDLE;
            end
        endcase
        busy_s = (state_s != ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            ptr_r    <= '0;
            winner_r <= '0;
            grant_r  <= '0;
            done_r   <= '0;
            start_r  <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            ptr_r    <= ptr_s;
            winner_r <= winner_s;
            grant_r  <= grant_s;
            done_r   <= done_s;
            start_r  <= start_s;
            busy_r   <= busy_s;
        end
    end

    // Read data from the granted RAM only; zero when nobody owns the engine.
    always_comb begin
        rd_mux_s = '0;
        for (int i = 0; i < R; i++) begin
            if (grant_r[i]) begin
                rd_mux_s = rd_mux_s | rq_rd_data[i*K +: K];
            end else begin
                rd_mux_s = rd_mux_s;
            end
        end
    end

    assign grant       = grant_r;
    assign done        = done_r;
    assign busy        = busy_r;
    assign eng_start   = start_r;
    assign eng_rd_data = rd_mux_s;
    assign rq_rd_addr  = eng_rd_addr;
    assign rq_wr_addr  = eng_wr_addr;
    assign rq_wr_data  = eng_wr_data;
    assign rq_wr_en    = grant_r & {R{eng_wr_en}};

endmodule

// File: tb/tb_shift_engine_arbiter.sv
// Randomized self-checking bench for shift_engine_arbiter against a round-robin reference model.
module tb_shift_engine_arbiter;

    localparam int K = 128;
    localparam int N = 32;
    localparam int R = 4;
    localparam int AW = $clog2(N);

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [R-1:0]   req = '0;
    logic [R-1:0]   grant, done, rq_wr_en;
    logic           busy, eng_start;
    logic           eng_end = 1'b0;
    logic [AW-1:0]  eng_rd_addr = '0, eng_wr_addr = '0, rq_rd_addr, rq_wr_addr;
    logic [K-1:0]   eng_rd_data, rq_wr_data;
    logic [K-1:0]   eng_wr_data = '0;
    logic           eng_wr_en = 1'b0;
    logic [R*K-1:0] rq_rd_data = '0;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int model_ptr = 0;

    // observations recorded by the serve task
    int         obs_wait;
    logic [R-1:0] obs_grant, obs_done, obs_grant_done;
    logic       obs_start, obs_start2, obs_busy_done, obs_busy_idle;

    shift_engine_arbiter #(.K(K), .N(N), .R(R)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .grant(grant), .done(done), .busy(busy),
        .eng_start(eng_start), .eng_end(eng_end), .eng_rd_addr(eng_rd_addr),
        .eng_rd_data(eng_rd_data), .eng_wr_addr(eng_wr_addr), .eng_wr_data(eng_wr_data),
        .eng_wr_en(eng_wr_en), .rq_rd_addr(rq_rd_addr), .rq_rd_data(rq_rd_data),
        .rq_wr_addr(rq_wr_addr), .rq_wr_data(rq_wr_data), .rq_wr_en(rq_wr_en)
    );

    always #5 clk = ~clk;

    // Invariants: grant one-hot or zero, never together with done.
    always @(negedge clk) begin
        if (rst_n) begin
            total++;
            if ((grant !== '0 && done !== '0) || $countones(grant) > 1) begin
                bad++;
                $display("FAIL invariant: grant=%b done=%b", grant, done);
            end
        end
    end

    function automatic int model_pick(input logic [R-1:0] r, input int p);
        for (int k = 0; k < R; k++) begin
            if (r[(p + k) % R]) return (p + k) % R;
        end
        return -1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        req = '0;
        eng_end = 1'b0;
        eng_wr_en = 1'b0;
        step();
        rst_n = 1'b1;
        model_ptr = 0;
        step();
    endtask

    // Engine + requester model: waits for a grant, ends the shift 'lat' cycles after start.
    task automatic serve(input int lat, input logic drop);
        obs_wait = -1;
        obs_grant = '0; obs_done = '0; obs_grant_done = '0;
        obs_start = 1'b0; obs_start2 = 1'b0; obs_busy_done = 1'b0; obs_busy_idle = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            step();
            if (grant !== '0) begin
                obs_wait = c;
                break;
            end
        end
        if (obs_wait < 0) return;
        obs_grant = grant;
        obs_start = eng_start;
        for (int c = 0; c < lat; c++) begin
            step();
            if (c == 0) obs_start2 = eng_start;
        end
        eng_end = 1'b1;
        step();
        eng_end = 1'b0;
        obs_done = done;
        obs_grant_done = grant;
        obs_busy_done = busy;
        if (drop) req = req & ~obs_grant;
        step();
        obs_busy_idle = busy;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        eng_wr_en = 1'b1;
        #3;
        total++;
        if (grant !== 4'b0000 || done !== 4'b0000 || busy !== 1'b0 || eng_start !== 1'b0) begin
            bad++;
            $display("FAIL reset_outputs: grant=%b done=%b busy=%b start=%b want 0", grant, done, busy, eng_start);
        end
        total++;
        if (rq_wr_en !== 4'b0000 || dut.ptr_r !== 2'd0) begin
            bad++;
            $display("FAIL reset_gating: rq_wr_en=%b ptr=%0d want 0000/0", rq_wr_en, dut.ptr_r);
        end
        eng_wr_en = 1'b0;
        apply_reset();
    endtask

    task automatic test_single();
        apply_reset();
        req = 4'b0010;
        serve(34, 1'b1);
        total++;
        if (obs_wait !== 1 || obs_grant !== 4'b0010 || obs_start !== 1'b1) begin
            bad++;
            $display("FAIL single_grant: wait=%0d grant=%b start=%b want 1/0010/1", obs_wait, obs_grant, obs_start);
        end
        total++;
        if (obs_start2 !== 1'b0) begin
            bad++;
            $display("FAIL single_start_pulse: start after GRANT=%b want 0", obs_start2);
        end
        total++;
        if (obs_done !== 4'b0010 || obs_grant_done !== 4'b0000 || obs_busy_done !== 1'b1) begin
            bad++;
            $display("FAIL single_done: done=%b grant=%b busy=%b want 0010/0000/1", obs_done, obs_grant_done, obs_busy_done);
        end
        total++;
        if (obs_busy_idle !== 1'b0 || dut.ptr_r !== 2'd2) begin
            bad++;
            $display("FAIL single_idle: busy=%b ptr=%0d want 0/2", obs_busy_idle, dut.ptr_r);
        end
        model_ptr = 2;
    endtask

    task automatic test_two();
        int w;
        apply_reset();
        req = 4'b0101;
        for (int t = 0; t < 4; t++) begin
            w = model_pick(req, model_ptr);
            serve($urandom_range(0, 6), 1'b0);
            model_ptr = (w + 1) % R;
            total++;
            if (obs_wait !== 1 || obs_grant !== 4'(1 << w) || obs_done !== 4'(1 << w)) begin
                bad++;
                $display("FAIL two_order[%0d]: wait=%0d grant=%b done=%b want 1/%b", t, obs_wait, obs_grant, obs_done, 4'(1 << w));
            end
            total++;
            if (dut.ptr_r !== 2'(model_ptr)) begin
                bad++;
                $display("FAIL two_ptr[%0d]: ptr=%0d want %0d", t, dut.ptr_r, model_ptr);
            end
        end
        req = '0;
    endtask

    task automatic test_all_four();
        int w;
        logic [R-1:0] seen;
        apply_reset();
        req = 4'b1111;
        seen = '0;
        for (int t = 0; t < 5; t++) begin
            w = model_pick(req, model_ptr);
            serve($urandom_range(1, 5), 1'b0);
            model_ptr = (w + 1) % R;
            total++;
            if (obs_grant !== 4'(1 << w) || obs_done !== 4'(1 << w)) begin
                bad++;
                $display("FAIL four_order[%0d]: grant=%b done=%b want %b", t, obs_grant, obs_done, 4'(1 << w));
            end
            if (t < 4) begin
                total++;
                if ((seen & obs_grant) !== '0) begin
                    bad++;
                    $display("FAIL four_fair[%0d]: grant=%b already served %b", t, obs_grant, seen);
                end
                seen = seen | obs_grant;
            end
        end
        req = '0;
    endtask

    task automatic test_random();
        int w;
        for (int t = 0; t < 20; t++) begin
            req = req | 4'($urandom_range(0, 15));
            if (req == '0) req = 4'($urandom_range(1, 15));
            w = model_pick(req, model_ptr);
            serve($urandom_range(0, 8), 1'b1);
            model_ptr = (w + 1) % R;
            total++;
            if (obs_wait !== 1 || obs_grant !== 4'(1 << w) || obs_done !== 4'(1 << w) || obs_busy_idle !== 1'b0) begin
                bad++;
                $display("FAIL random[%0d]: wait=%0d grant=%b done=%b busy=%b want 1/%b/%b/0", t, obs_wait, obs_grant, obs_done, obs_busy_idle, 4'(1 << w), 4'(1 << w));
            end
        end
        req = '0;
    endtask

    task automatic test_write_steer();
        logic [K-1:0] pat;
        pat = {16{8'hA5}};
        req = 4'b0100;
        step();
        total++;
        if (grant !== 4'b0100) begin
            bad++;
            $display("FAIL steer_grant: grant=%b want 0100", grant);
        end
        for (int i = 0; i < R; i++) rq_rd_data[i*K +: K] = {$urandom, $urandom, $urandom, $urandom};
        rq_rd_data[2*K +: K] = 128'h1234;
        eng_wr_en = 1'b1;
        eng_wr_addr = 5'd3;
        eng_wr_data = pat;
        eng_rd_addr = 5'd7;
        #1;
        total++;
        if (rq_wr_en !== 4'b0100 || rq_wr_addr !== 5'd3 || rq_wr_data !== pat || rq_rd_addr !== 5'd7) begin
            bad++;
            $display("FAIL steer_write: wr_en=%b wr_addr=%0d rd_addr=%0d want 0100/3/7", rq_wr_en, rq_wr_addr, rq_rd_addr);
        end
        total++;
        if (eng_rd_data !== 128'h1234) begin
            bad++;
            $display("FAIL steer_read: eng_rd_data=%h want 1234", eng_rd_data);
        end
        eng_wr_en = 1'b0;
        step();
        eng_end = 1'b1;
        step();
        eng_end = 1'b0;
        req = '0;
        step();
        model_ptr = 3;
        eng_wr_en = 1'b1;
        #1;
        total++;
        if (rq_wr_en !== 4'b0000 || eng_rd_data !== '0) begin
            bad++;
            $display("FAIL steer_nogrant: wr_en=%b rd_data=%h want 0000/0", rq_wr_en, eng_rd_data);
        end
        eng_wr_en = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        req = 4'b0010;
        step();
        for (int c = 0; c < 20; c++) step();
        total++;
        if (grant !== 4'b0010 || busy !== 1'b1) begin
            bad++;
            $display("FAIL midrun_hold: grant=%b busy=%b want 0010/1", grant, busy);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if (grant !== '0 || done !== '0 || busy !== 1'b0 || dut.ptr_r !== 2'd0) begin
            bad++;
            $display("FAIL midrun_reset: grant=%b done=%b busy=%b ptr=%0d want 0", grant, done, busy, dut.ptr_r);
        end
        req = '0;
        step();
        step();
        rst_n = 1'b1;
        model_ptr = 0;
        req = 4'b1000;
        serve(5, 1'b1);
        model_ptr = 0;
        total++;
        if (obs_wait !== 1 || obs_grant !== 4'b1000 || obs_done !== 4'b1000) begin
            bad++;
            $display("FAIL midrun_after: wait=%0d grant=%b done=%b want 1/1000/1000", obs_wait, obs_grant, obs_done);
        end
    endtask

    task automatic test_robust();
        int w, o;
        logic [R-1:0] d_seen;
        eng_end = 1'b1;
        step();
        eng_end = 1'b0;
        d_seen = done;
        step();
        d_seen = d_seen | done;
        total++;
        if (d_seen !== '0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL stray_end: done=%b busy=%b want 0000/0", d_seen, busy);
        end
        req = 4'b0011;
        w = model_pick(req, model_ptr);
        o = (w == 0) ? 1 : 0;
        step();
        step();
        req = req & ~4'(1 << w);
        step();
        step();
        total++;
        if (grant !== 4'(1 << w)) begin
            bad++;
            $display("FAIL abandon_hold: grant=%b want %b", grant, 4'(1 << w));
        end
        eng_end = 1'b1;
        step();
        eng_end = 1'b0;
        total++;
        if (done !== 4'(1 << w)) begin
            bad++;
            $display("FAIL abandon_done: done=%b want %b", done, 4'(1 << w));
        end
        model_ptr = (w + 1) % R;
        step();
        total++;
        if (done !== '0) begin
            bad++;
            $display("FAIL abandon_once: done=%b want 0000", done);
        end
        serve(2, 1'b1);
        model_ptr = (o + 1) % R;
        total++;
        if (obs_grant !== 4'(1 << o) || obs_done !== 4'(1 << o)) begin
            bad++;
            $display("FAIL abandon_next: grant=%b done=%b want %b", obs_grant, obs_done, 4'(1 << o));
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_two();
        test_all_four();
        test_random();
        test_write_steer();
        test_reset_mid_run();
        test_robust();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/shift_engine_arbiter.md
# shift_engine_arbiter

Round-robin arbiter and sequencer that shares one word-serial `right_shift_operation` engine among up to R requesters, such as the x/y operand RAMs and the u/v/A/B/C/D working RAMs of the modular inverse. It grants the engine to one requester at a time and issues the engine's start pulse. While a grant is held, it steers the engine's RAM read and write ports to the granted requester's RAM. It returns a one-cycle completion pulse to that requester. This lets the modular-inverse controller use one shifter instead of one per operand.

## Interface
- `K`, default 128: RAM word width in bits.
- `N`, default 32: words per operand. `ADDR_W = $clog2(N)`.
- `R`, default 4: number of requesters, R ≥ 2.

- `clk`  in  1  sole clock; all logic is on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req`  in  R  level request per requester; held until `done` for that requester.
- `grant`  out  R  one-hot or zero; the current engine owner.
- `done`  out  R  one-cycle pulse to the owner when its shift completes.
- `busy`  out  1  high in every state other than IDLE.
- `eng_start`  out  1  one-cycle start pulse to the engine.
- `eng_end`  in  1  engine completion pulse.
- `eng_rd_addr`  in  ADDR_W  engine read address.
- `eng_rd_data`  out  K  read data from the granted RAM.
- `eng_wr_addr`  in  ADDR_W  engine write address.
- `eng_wr_data`  in  K  engine write data.
- `eng_wr_en`  in  1  engine write enable.
- `rq_rd_addr`  out  ADDR_W  shared read address to all requester RAMs.
- `rq_rd_data`  in  R*K  RAM q buses; requester i drives slice [i*K +: K].
- `rq_wr_addr`  out  ADDR_W  shared write address.
- `rq_wr_data`  out  K  shared write data.
- `rq_wr_en`  out  R  per-RAM write enable.

## Operation
- **States:** IDLE, GRANT, RUN, DONE, encoded in 2 bits.
- **IDLE:**
  - If `req` is not 0, select the winner: the first set bit searching upward from `ptr`, modulo R.
  - Next cycle: `grant` = one-hot(winner), `eng_start` = 1, state = GRANT.
- **GRANT:** lasts one cycle. `eng_start` falls to 0 on leaving it. State goes to RUN.
- **RUN:**
  - `grant` is held.
  - When `eng_end` = 1: next cycle `grant` = 0, `done[winner]` = 1, `ptr` = (winner+1) mod R, state = DONE.
  - `eng_end` is also accepted in GRANT, which covers a zero-latency engine; the transition to DONE is identical.
- **DONE:** lasts one cycle, then IDLE. `req` is not sampled in DONE.
- **Requester rule:** a requester deasserts `req` on the edge that ends its `done` cycle. If its `req` is still high in IDLE, that is a new request and is arbitrated fairly against the others.
- **Abandoned requests:** a `req` dropped during GRANT/RUN is ignored. The engine cannot be aborted, so the cycle completes and `done` still pulses.
- **Stray end pulse:** `eng_end` in IDLE or DONE is ignored.
- **Port steering (combinational):**
  - `rq_rd_addr` = `eng_rd_addr`; `rq_wr_addr` = `eng_wr_addr`; `rq_wr_data` = `eng_wr_data`.
  - `rq_wr_en[i]` = `eng_wr_en` & `grant[i]`, so no RAM is written without a grant.
  - `eng_rd_data` = `rq_rd_data` slice of the granted index. It is 0 when `grant` = 0.
- **Invariants:** `grant` and `done` are never both nonzero. `grant` is one-hot or zero.

## Timing
- **Reset values** (async assert, sync-safe release): state IDLE, `ptr` = 0, and `grant`, `done`, `eng_start`, `busy` all 0. Steered outputs follow their inputs, gated by `grant` = 0.
- **Reset mid-RUN:** all of the above is restored at once, with no `done` pulse. The engine shares `rst_n`.
- **Latency:**
  - `req` sampled in IDLE at cycle t: `grant` and `eng_start` at t+1.
  - `eng_end` at cycle e: `done` at e+1, IDLE at e+2.
  - Earliest next grant: e+3.
- **Throughput:** one shift per (engine latency + 3) cycles.

## Test plan
- **Single request:** K=128, N=32, R=4; engine model latency 34 cycles; `req` = 0010 at cycle 10 → `grant` = 0010 and `eng_start` at 11; `eng_end` at 45; `done` = 0010 at 46; `busy` low at 47.
- **Two simultaneous requesters:** `req` = 0101 held throughout, each requester re-requesting after its `done` → grants in the order 0001, 0100, 0001, 0100, with `ptr` checked after each `done`.
- **All four requesters:** `req` = 1111 held → grants 0001, 0010, 0100, 1000, 0001, and no requester is granted twice before every other requester has been granted once.
- **Write steering:** the engine writes 0xA5…A5 to address 3 while `grant` = 0100 → `rq_wr_en` = 0100 and `rq_wr_addr` = 3. Read of slice 2 = 0x1234 → `eng_rd_data` = 0x1234. With no grant, `rq_wr_en` = 0000.
- **Reset mid-RUN:** `rst_n` low at cycle 20 of RUN → `grant`, `done`, `busy` all 0 the same cycle and `ptr` = 0. After release, `req` = 1000 is granted normally.
- **Robustness:** `eng_end` pulsed in IDLE → no `done`. `req` dropped mid-RUN → `done` still pulses once, and that requester is not regranted.
